// File: rtl/rgb2hsv_pipe.sv
// Streaming 8-bit RGB to HSV converter: H in degrees, S as an 11-bit fraction, V = max channel.
// Sixteen-stage pipeline with two parallel 12-step restoring dividers; sideband travels alongside each pixel.
module rgb2hsv_pipe #(
    parameter int SB_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [7:0]      r,
    input  logic [7:0]      g,
    input  logic [7:0]      b,
    input  logic [SB_W-1:0] in_sb,
    output logic            out_valid,
    output logic [8:0]      H,
    output logic [10:0]     S,
    output logic [7:0]      V,
    output logic [SB_W-1:0] out_sb
);

    // Divider state for one pixel: partial remainder, unconsumed dividend bits, quotient so far.
    typedef struct packed {
        logic [7:0]      rem_s;
        logic [11:0]     bits_s;
        logic [11:0]     q_s;
        logic [7:0]      rem_h;
        logic [11:0]     bits_h;
        logic [11:0]     q_h;
        logic [7:0]      vmax;
        logic [7:0]      delta;
        logic [1:0]      sector;
        logic            neg;
        logic [SB_W-1:0] sb;
    } div_t;

    function automatic div_t div_step(input div_t x);
        div_t       y;
        logic [8:0] t;
        y = x;
        t = {x.rem_s, x.bits_s[11]};
        if (t >= {1'b0, x.vmax}) begin
            y.rem_s = 8'(t - {1'b0, x.vmax});
            y.q_s   = {x.q_s[10:0], 1'b1};
        end else begin
            y.rem_s = t[7:0];
            y.q_s   = {x.q_s[10:0], 1'b0};
        end
        y.bits_s = {x.bits_s[10:0], 1'b0};
        t = {x.rem_h, x.bits_h[11]};
        if (t >= {1'b0, x.delta}) begin
            y.rem_h = 8'(t - {1'b0, x.delta});
            y.q_h   = {x.q_h[10:0], 1'b1};
        end else begin
            y.rem_h = t[7:0];
            y.q_h   = {x.q_h[10:0], 1'b0};
        end
        y.bits_h = {x.bits_h[10:0], 1'b0};
        return y;
    endfunction

    logic [15:1]     vld;
    logic [7:0]      r1, g1, b1;
    logic [SB_W-1:0] sb1;
    div_t            d0_next;
    div_t            d [0:12];
    logic [7:0]      mx, mn, dl, opa, opc, mag;
    logic [1:0]      sect;
    logic [13:0]     num_h;
    logic [9:0]      base, qh, hue;
    logic [10:0]     sat;
    logic [8:0]      h15;
    logic [10:0]     s15;
    logic [7:0]      v15;
    logic [SB_W-1:0] sb15;

    always_ff @(posedge clk) begin
        if (rst) vld <= '0;
        else     vld <= {vld[14:1], in_valid};
    end

    // NOTE: datapath registers carry no reset; only the valid chain decides what is ever emitted.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r1  <= r;
            g1  <= g;
            b1  <= b;
            sb1 <= in_sb;
        end
    end

    // Sector selection with tie priority r, g, b; opa - opc is the hue difference.
    always_comb begin
        mx   = b1;
        sect = 2'd2;
        opa  = r1;
        opc  = g1;
        if (r1 >= g1 && r1 >= b1) begin
            mx = r1; sect = 2'd0; opa = g1; opc = b1;
        end else if (g1 >= b1) begin
            mx = g1; sect = 2'd1; opa = b1; opc = r1;
        end
        mn = (r1 <= g1) ? ((r1 <= b1) ? r1 : b1) : ((g1 <= b1) ? g1 : b1);
        dl    = mx - mn;
        mag   = (opa < opc) ? (opc - opa) : (opa - opc);
        num_h = 14'(mag) * 14'd60;

        d0_next        = '0;
        d0_next.rem_s  = {1'b0, dl[7:1]};
        d0_next.bits_s = {dl[0], 11'b0};
        d0_next.rem_h  = {6'b0, num_h[13:12]};
        d0_next.bits_h = num_h[11:0];
        d0_next.vmax   = mx;
        d0_next.delta  = dl;
        d0_next.sector = sect;
        d0_next.neg    = (opa < opc);
        d0_next.sb     = sb1;
    end

    always_ff @(posedge clk) begin
        if (vld[1]) d[0] <= d0_next;
    end

    for (genvar k = 1; k <= 12; k++) begin : g_div
        always_ff @(posedge clk) begin
            if (vld[k+1]) d[k] <= div_step(d[k-1]);
        end
    end

    always_comb begin
        base = (d[12].sector == 2'd0) ? 10'd0 : (d[12].sector == 2'd1) ? 10'd120 : 10'd240;
        qh   = {4'b0, d[12].q_h[5:0]};
        if (d[12].delta == 8'd0)  hue = 10'd0;
        else if (!d[12].neg)      hue = base + qh;
        else if (base < qh)       hue = base + 10'd360 - qh;
        else                      hue = base - qh;
        if (hue == 10'd360) hue = 10'd0;
        if (d[12].vmax == 8'd0)   sat = 11'd0;
        else if (d[12].q_s[11])   sat = 11'd2047;
        else                      sat = d[12].q_s[10:0];
    end

    always_ff @(posedge clk) begin
        if (vld[14]) begin
            h15  <= hue[8:0];
            s15  <= sat;
            v15  <= d[12].vmax;
            sb15 <= d[12].sb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            H         <= '0;
            S         <= '0;
            V         <= '0;
            out_sb    <= '0;
        end else begin
            out_valid <= vld[15];
            if (vld[15]) begin
                H      <= h15;
                S      <= s15;
                V      <= v15;
                out_sb <= sb15;
            end
        end
    end

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Scoreboard bench for rgb2hsv_pipe: directed spec pixels plus random traffic against an
// integer HSV reference model, with the output valid pattern checked against a 16-cycle delay.
module tb_rgb2hsv_pipe;

    localparam int SB_W = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [7:0]      r = '0, g = '0, b = '0;
    logic [SB_W-1:0] in_sb = '0;
    logic            out_valid;
    logic [8:0]      H;
    logic [10:0]     S;
    logic [7:0]      V;
    logic [SB_W-1:0] out_sb;

    rgb2hsv_pipe #(.SB_W(SB_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .r(r), .g(g), .b(b), .in_sb(in_sb),
        .out_valid(out_valid), .H(H), .S(S), .V(V), .out_sb(out_sb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int s;
        int v;
        int sb;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hist = '0;
    bit          mon_en = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;
    int          sb_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Reference HSV from the textbook definitions using plain signed integers.
    function automatic exp_t model(input int rr, input int gg, input int bb, input int sb);
        exp_t e;
        int mx, mn, dl, diff, base, q, hh, ss;
        mx = (rr > gg) ? rr : gg;  mx = (mx > bb) ? mx : bb;
        mn = (rr < gg) ? rr : gg;  mn = (mn < bb) ? mn : bb;
        dl = mx - mn;
        if (rr == mx)      begin diff = gg - bb; base = 0;   end
        else if (gg == mx) begin diff = bb - rr; base = 120; end
        else               begin diff = rr - gg; base = 240; end
        ss = (mx == 0) ? 0 : (dl * 2048) / mx;
        if (ss > 2047) ss = 2047;
        if (dl == 0) hh = 0;
        else begin
            q  = (60 * ((diff < 0) ? -diff : diff)) / dl;
            hh = (diff >= 0) ? base + q : base - q;
            if (hh < 0) hh += 360;
            if (hh == 360) hh = 0;
        end
        e.h = hh; e.s = ss; e.v = mx; e.sb = sb;
        return e;
    endfunction

    // Expected out_valid is in_valid delayed 16 edges; reset wipes both history and pending results.
    always @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            exp_q.delete();
        end else begin
            hist <= {hist[14:0], in_valid};
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(hist[15]));
            if (out_valid === 1'b1) begin
                check("pending_result", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("H", 32'(H), 32'(e.h));
                    check("S", 32'(S), 32'(e.s));
                    check("V", 32'(V), 32'(e.v));
                    check("out_sb", 32'(out_sb), 32'(e.sb));
                end
            end
        end
    end

    task automatic send_exp(input int rr, input int gg, input int bb, input exp_t e);
        @(posedge clk); #1;
        in_valid = 1'b1;
        r = 8'(rr); g = 8'(gg); b = 8'(bb);
        in_sb = SB_W'(sb_cnt);
        e.sb = sb_cnt % (1 << SB_W);
        exp_q.push_back(e);
        sb_cnt++;
    endtask

    task automatic send_const(input int rr, input int gg, input int bb, input int hh, input int ss, input int vv);
        exp_t e;
        e.h = hh; e.s = ss; e.v = vv; e.sb = 0;
        send_exp(rr, gg, bb, e);
    endtask

    task automatic send_rand();
        int rr, gg, bb;
        rr = $urandom_range(0, 255); gg = $urandom_range(0, 255); bb = $urandom_range(0, 255);
        case ($urandom_range(0, 4))
            0: gg = rr;
            1: bb = (rr > gg) ? rr : gg;
            2: begin gg = rr; bb = rr; end
            3: bb = 0;
            default: ;
        endcase
        send_exp(rr, gg, bb, model(rr, gg, bb, sb_cnt % (1 << SB_W)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_sb = SB_W'(sb_cnt);
            sb_cnt++;
        end
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < 65) send_rand();
            else idle(1);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_H", 32'(H), 32'd0);
        check("rst_S", 32'(S), 32'd0);
        check("rst_V", 32'(V), 32'd0);
        check("rst_out_sb", 32'(out_sb), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_H", 32'(H), 32'd0);
        check("init_S", 32'(S), 32'd0);
        check("init_V", 32'(V), 32'd0);

        // Primaries back-to-back, then greys, mixed hues and half saturation.
        send_const(255, 0, 0,     0, 2047, 255);
        send_const(0, 255, 0,   120, 2047, 255);
        send_const(0, 0, 255,   240, 2047, 255);
        send_const(0, 0, 0,       0,    0,   0);
        send_const(128, 128, 128, 0,    0, 128);
        send_const(255, 128, 0,  30, 2047, 255);
        send_const(255, 0, 128, 330, 2047, 255);
        send_const(200, 100, 100, 0, 1024, 200);
        send_const(100, 200, 200, 180, 1024, 200);
        idle(20);

        random_traffic(400);
        idle(20);

        // Reset with pixels in flight; then one pixel straight after reset.
        random_traffic(10);
        pulse_reset();
        send_rand();
        idle(20);
        random_traffic(200);
        idle(20);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
